// File: rtl/wb_register_file.sv
// Architectural register file at the end of the write-back path.
// Two combinational read ports with same-cycle write-first bypass, a debug
// read port showing committed state only, and a committed-write counter.
// Register 0 reads as zero on every port and is never written.
module wb_register_file #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned NUM_REGS = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_wb_en,
   input  logic [ADDR_W-1:0] i_wb_addr,
   input  logic [DATA_W-1:0] i_wb_data,
   input  logic [ADDR_W-1:0] i_rs_addr,
   input  logic [ADDR_W-1:0] i_rt_addr,
   output logic [DATA_W-1:0] o_rs_data,
   output logic [DATA_W-1:0] o_rt_data,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [DATA_W-1:0] o_dbg_data,
   output logic [31:0]       o_wb_count
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [31:0]       r_wb_count;
   logic              w_commit;

   // A write commits only outside reset and never to r0.
   assign w_commit = i_wb_en && (i_wb_addr != '0) && !i_rst;

   // Read priority: r0 -> zero, then same-cycle bypass, then stored value.
   // The bypass is deliberately not gated by reset.
   function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
      if (addr == '0) begin
         return '0;
      end else if (i_wb_en && (i_wb_addr == addr)) begin
         return i_wb_data;
      end else begin
         return r_regs[addr];
      end
   endfunction

   // Array and counter update: reset clears everything and drops any write.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_regs     <= '{default: '0};
         r_wb_count <= '0;
      end else if (w_commit) begin
         r_regs[i_wb_addr] <= i_wb_data;
         r_wb_count        <= r_wb_count + 32'd1;
      end
   end

   // Combinational read ports for decode and debug.
   always_comb begin
      o_rs_data  = f_read(i_rs_addr);
      o_rt_data  = f_read(i_rt_addr);
      o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
   end

   assign o_wb_count = r_wb_count;

endmodule

// File: tb/tb_wb_register_file.sv
// Self-checking bench for wb_register_file: directed vector table, a
// back-to-back fill with counter wrap, and randomized traffic checked
// against an array-based reference model.
module tb_wb_register_file;

   logic        clk;
   logic        rst;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic [31:0] wb_count;

   int errors = 0;
   int checks = 0;

   // Reference model: committed register contents and commit count.
   logic [31:0] m_regs [32];
   logic [31:0] m_count;

   wb_register_file #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_REGS (32)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wb_en    (wb_en),
      .i_wb_addr  (wb_addr),
      .i_wb_data  (wb_data),
      .i_rs_addr  (rs_addr),
      .i_rt_addr  (rt_addr),
      .o_rs_data  (rs_data),
      .o_rt_data  (rt_data),
      .i_dbg_addr (dbg_addr),
      .o_dbg_data (dbg_data),
      .o_wb_count (wb_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        en;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  dbg;
      logic [31:0] exp_rs;   // before the edge
      logic [31:0] exp_rt;   // before the edge
      logic [31:0] exp_dbg;  // before the edge
      logic [31:0] exp_cnt;  // after the edge
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic en, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] dbg);
      rst      = r;
      wb_en    = en;
      wb_addr  = wa;
      wb_data  = wd;
      rs_addr  = ra;
      rt_addr  = rb;
      dbg_addr = dbg;
   endtask

   // Value a decode read port should show right now.
   function automatic logic [31:0] model_read(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (wb_en && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   function automatic logic [31:0] model_dbg(input logic [4:0] a);
      return (a == 5'd0) ? 32'd0 : m_regs[a];
   endfunction

   // Advance one clock; model commits with the inputs seen at the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_count = 32'd0;
      end else if (wb_en && wb_addr != 5'd0) begin
         m_regs[wb_addr] = wb_data;
         m_count         = m_count + 32'd1;
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_count = 32'd0;

      vecs[0]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd31, 5'd17, 32'h0, 32'h0, 32'h0, 32'd0};
      vecs[1]  = '{1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd4,  5'd3,  32'hDEADBEEF, 32'h0, 32'h0, 32'd1};
      vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd3,  5'd3,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
      vecs[3]  = '{1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'd2};
      vecs[4]  = '{1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7,  5'd7,  32'h22222222, 32'h22222222, 32'h11111111, 32'd3};
      vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd3,  5'd7,  32'h22222222, 32'hDEADBEEF, 32'h22222222, 32'd3};
      vecs[6]  = '{1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7,  5'd0,  32'h0, 32'h22222222, 32'h0, 32'd3};
      vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0,  5'd0,  32'h0, 32'h0, 32'h0, 32'd3};
      vecs[8]  = '{1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd1,  5'd9,  32'hA5A5A5A5, 32'h0, 32'h0, 32'd4};
      vecs[9]  = '{1'b1, 1'b1, 5'd9, 32'h5A5A5A5A, 5'd9, 5'd9,  5'd9,  32'h5A5A5A5A, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'd0};
      vecs[10] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd3,  5'd9,  32'h0, 32'h0, 32'h0, 32'd0};
      vecs[11] = '{1'b0, 1'b1, 5'd9, 32'h1,        5'd3, 5'd9,  5'd9,  32'h0, 32'h1, 32'h0, 32'd1};
      vecs[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd9,  5'd9,  32'h1, 32'h1, 32'h1, 32'd1};

      // Two-cycle reset.
      drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd17);
      tick();
      tick();
      @(negedge clk);
      check("reset_count", wb_count, 32'd0);

      // Directed vector table.
      for (int v = 0; v < 13; v++) begin
         drive(vecs[v].rst, vecs[v].en, vecs[v].wa, vecs[v].wd,
               vecs[v].ra, vecs[v].rb, vecs[v].dbg);
         #2;
         check($sformatf("vec%0d_rs", v), rs_data, vecs[v].exp_rs);
         check($sformatf("vec%0d_rt", v), rt_data, vecs[v].exp_rt);
         check($sformatf("vec%0d_dbg", v), dbg_data, vecs[v].exp_dbg);
         tick();
         check($sformatf("vec%0d_cnt", v), wb_count, vecs[v].exp_cnt);
         @(negedge clk);
      end

      // Back-to-back fill of r1..r31 after a fresh reset.
      drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      tick();
      @(negedge clk);
      for (int i = 1; i < 32; i++) begin
         drive(1'b0, 1'b1, 5'(i), 32'(i) * 32'h01010101, 5'd0, 5'd0, 5'd0);
         tick();
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1;
         check($sformatf("fill_dbg%0d", i), dbg_data, 32'(i) * 32'h01010101);
      end
      check("fill_count", wb_count, 32'd31);

      // Counter wrap: deposit all-ones, then commit one write.
      dut.r_wb_count = 32'hFFFF_FFFF;
      m_count        = 32'hFFFF_FFFF;
      drive(1'b0, 1'b1, 5'd5, 32'h0BADF00D, 5'd5, 5'd0, 5'd5);
      tick();
      check("wrap_count", wb_count, 32'd0);
      @(negedge clk);

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         logic [4:0] hot;
         hot = 5'($urandom_range(0, 3));
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 1) == 1),
               ($urandom_range(0, 1) == 1) ? hot : 5'($urandom),
               $urandom,
               ($urandom_range(0, 1) == 1) ? hot : 5'($urandom),
               ($urandom_range(0, 1) == 1) ? hot : 5'($urandom),
               ($urandom_range(0, 1) == 1) ? hot : 5'($urandom));
         #2;
         check("rand_rs", rs_data, model_read(rs_addr));
         check("rand_rt", rt_data, model_read(rt_addr));
         check("rand_dbg", dbg_data, model_dbg(dbg_addr));
         tick();
         check("rand_cnt", wb_count, m_count);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Architectural register file at the far end of the write-back path in the 5-stage pipeline.
- Accepts the selected write-back value (load data or ALU result) plus destination and write enable from the WB stage, and commits it on the clock edge.
- Serves two combinational read ports to the decode (ID) stage, with same-cycle WB-to-ID bypass so decode never reads a stale value.
- Provides a debug read port and a committed-write counter for the bench.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wb_en  input  1  RegWrite from the WB stage; commit this cycle when high.
- wb_addr  input  ADDR_W  destination register index.
- wb_data  input  DATA_W  write-back value (load data if MemtoReg, else ALU result).
- rs_addr  input  ADDR_W  read port A index (ID stage).
- rt_addr  input  ADDR_W  read port B index (ID stage).
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- dbg_addr  input  ADDR_W  debug read index.
- dbg_data  output  DATA_W  debug read data (array contents only, no bypass).
- wb_count  output  32  count of committed writes.

Behaviour:
- Storage: NUM_REGS x DATA_W array. Register 0 is hardwired to zero:
  - A write to index 0 is discarded.
  - Reads of index 0 return 0 on every port, including under bypass.
- Write: on rising clk, if !rst && wb_en && wb_addr != 0, then array[wb_addr] <= wb_data. Latency is one cycle; the array value is visible to the non-bypassed path from the next cycle.
- Read ports A/B are combinational. Priority per port:
  - (1) index == 0 -> 0.
  - (2) wb_en && wb_addr == index -> wb_data. This is the write-first bypass in the same cycle as the write.
  - (3) otherwise array[index].
- Both read ports may hit the same index and the bypass simultaneously; both return wb_data.
- Debug port is combinational: dbg_data = array[dbg_addr] (0 for index 0). It has no bypass, so it shows committed state only.
- wb_count:
  - Increments by 1 on each rising edge where a write actually commits (wb_en && wb_addr != 0 && !rst).
  - Writes to r0 do not count.
  - Wraps from 0xFFFFFFFF to 0 with no flag.
- Reset (synchronous, active-high):
  - On a rising edge with rst=1, every array entry goes to 0 and wb_count goes to 0.
  - A write presented in the same cycle is dropped.
- During a reset cycle the read ports still apply the combinational priority. Bypass stays active (reset does not gate it); after the edge the array reads 0.
- Reset asserted mid-stream: all prior writes are lost. The first write after rst deasserts commits normally.
- Post-reset output values: rs_data = rt_data = dbg_data = 0 (for any address with wb_en=0), wb_count = 0.
- No X propagation: wb_addr and wb_data are don't-care when wb_en=0.

Test Plan:
- Reset then read: rst for 2 cycles; rs_addr=5, rt_addr=31, dbg_addr=17 with wb_en=0 -> all data outputs 0, wb_count=0.
- Basic write/read: write r3=0xDEADBEEF (wb_en=1, one cycle), then wb_en=0, rs_addr=3 -> rs_data=0xDEADBEEF, dbg_data(3)=0xDEADBEEF, wb_count=1.
- Same-cycle bypass: array r7=0x11111111. In one cycle drive wb_en=1, wb_addr=7, wb_data=0x22222222, rs_addr=rt_addr=7 -> rs_data=rt_data=0x22222222 in that cycle; dbg_data(7)=0x11111111 before the edge and 0x22222222 after.
- r0 protection: wb_en=1, wb_addr=0, wb_data=0xFFFFFFFF, rs_addr=0 -> rs_data=0 in the same cycle and after; dbg_data(0)=0; wb_count unchanged.
- Reset collides with write: r9=0xA5A5A5A5 committed; next cycle rst=1 with wb_en=1, wb_addr=9, wb_data=0x5A5A5A5A -> after the edge dbg_data(9)=0, wb_count=0. Next cycle (rst=0) write r9=0x1 -> r9=0x1, wb_count=1.
- Back-to-back writes and counter: write r1..r31 on consecutive cycles with data = index*0x01010101 -> every dbg read matches, wb_count=31. Force wb_count to 0xFFFFFFFF (via hierarchical deposit) and write once -> wb_count=0.
